// File: rtl/spi_pkg.sv
// Shared op encodings, frame sizes and FSM state type for the SPI master controller.
package spi_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RECV  = 3'd4,
    ST_GAP   = 3'd5
  } spi_mst_state_t;

endpackage

// File: rtl/spi_mst_shifter.sv
// MSB-first 10-bit shift-out register and MISO shift-in register, both sequenced by the
// controller FSM through load/shift enables.
module spi_mst_shifter
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  shift_out,
  input  logic                  shift_in,
  input  logic                  miso,
  output logic                  tx_bit,
  output logic                  tx_next_bit,
  output logic [DATA_BITS-1:0]  rx_word
);

  logic [FRAME_BITS-1:0] tx;
  logic [DATA_BITS-2:0]  rx;

  // The eighth sample bypasses the register so the full byte is ready on the last RECV edge.
  assign rx_word     = {rx, miso};
  assign tx_bit      = tx[FRAME_BITS-1];
  assign tx_next_bit = tx[FRAME_BITS-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= '0;
      rx <= '0;
    end else begin
      if (load) begin
        tx <= frame;
      end else if (shift_out) begin
        tx <= {tx[FRAME_BITS-2:0], 1'b0};
      end
      if (shift_in) begin
        rx <= rx_word[DATA_BITS-2:0];
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: serialises one RAM command per frame on SS_n/MOSI and,
// for read-data commands, collects the reply byte from MISO.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [3:0] BIT_LAST  = 4'(FRAME_BITS - 1);
  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] RECV_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

  spi_mst_state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       is_read, is_read_nx;
  logic       ss_n_nx, mosi_nx, rd_valid_nx, cmd_ready_nx, busy_nx;
  logic [7:0] rd_data_nx;
  logic       accept, load, shift_out, shift_in, tx_bit, tx_next_bit;
  logic [7:0] rx_word;

  assign accept = cmd_valid && cmd_ready;

  spi_mst_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .frame       ({cmd_op, cmd_data}),
    .shift_out   (shift_out),
    .shift_in    (shift_in),
    .miso        (MISO),
    .tx_bit      (tx_bit),
    .tx_next_bit (tx_next_bit),
    .rx_word     (rx_word)
  );

  // Outputs are computed for the next state and registered, so pins line up with the state.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    is_read_nx  = is_read;
    ss_n_nx     = 1'b1;
    mosi_nx     = 1'b0;
    rd_valid_nx = 1'b0;
    rd_data_nx  = rd_data;
    load        = 1'b0;
    shift_out   = 1'b0;
    shift_in    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx   = ST_START;
          cnt_nx     = 4'd0;
          is_read_nx = (cmd_op == OP_RD_DATA);
          load       = 1'b1;
          ss_n_nx    = 1'b0;
          mosi_nx    = cmd_op[1];
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        state_nx = ST_SHIFT;
        cnt_nx   = 4'd0;
        ss_n_nx  = 1'b0;
        mosi_nx  = tx_bit;
      end
      ST_SHIFT: begin
        if (cnt == BIT_LAST) begin
          cnt_nx = 4'd0;
          if (is_read) begin
            state_nx = ST_WAIT;
            ss_n_nx  = 1'b0;
          end else begin
            state_nx = ST_GAP;
          end
        end else begin
          cnt_nx    = cnt + 4'd1;
          shift_out = 1'b1;
          ss_n_nx   = 1'b0;
          mosi_nx   = tx_next_bit;
        end
      end
      ST_WAIT: begin
        ss_n_nx = 1'b0;
        if (cnt == WAIT_LAST) begin
          state_nx = ST_RECV;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      ST_RECV: begin
        shift_in = 1'b1;
        if (cnt == RECV_LAST) begin
          state_nx    = ST_GAP;
          cnt_nx      = 4'd0;
          rd_valid_nx = 1'b1;
          rd_data_nx  = rx_word;
        end else begin
          cnt_nx  = cnt + 4'd1;
          ss_n_nx = 1'b0;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
    cmd_ready_nx = (state_nx == ST_IDLE);
    busy_nx      = (state_nx != ST_IDLE);
  end

  // State, counter and all output registers; reset abandons any frame without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      is_read   <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      is_read   <= is_read_nx;
      SS_n      <= ss_n_nx;
      MOSI      <= mosi_nx;
      cmd_ready <= cmd_ready_nx;
      busy      <= busy_nx;
      rd_valid  <= rd_valid_nx;
      rd_data   <= rd_data_nx;
    end
  end

endmodule
